// File: rtl/bp_mem_lite_ram_pkg.sv
// BedRock lite memory message types for the block-RAM memory endpoint.
// Header layout mirrors the cce-flavoured BedRock mem header.
package bp_mem_lite_ram_pkg;

  localparam int unsigned paddr_width     = 40;
  localparam int unsigned cce_block_width = 512;
  localparam int unsigned block_bytes     = cce_block_width / 8;
  localparam int unsigned lg_block_bytes  = $clog2(block_bytes);
  localparam int unsigned payload_width   = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width-1:0] payload;
    bp_bedrock_msg_size_e     size;
    logic [paddr_width-1:0]   addr;
    logic [3:0]               subop;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [cce_block_width-1:0] data;
    bp_bedrock_mem_header_s     header;
  } bp_bedrock_mem_msg_s;

  localparam int unsigned mem_header_width  = $bits(bp_bedrock_mem_header_s);
  localparam int unsigned cce_mem_msg_width = $bits(bp_bedrock_mem_msg_s);

  // Low-order byte-offset bits covered by an access of this size; sizes above a block clamp to a block.
  function automatic logic [lg_block_bytes-1:0] size_mask(input bp_bedrock_msg_size_e size);
    size_mask = '0;
    for (int i = 0; i < lg_block_bytes; i++) begin
      if (i < int'(size)) size_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables.
// Read data appears the cycle after a read access; contents are never reset.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int unsigned width_p = 512,
  parameter int unsigned els_p   = 1024
) (
  input  logic                       clk_i,
  input  logic                       v_i,
  input  logic                       w_i,
  input  logic [$clog2(els_p)-1:0]   addr_i,
  input  logic [width_p-1:0]         data_i,
  input  logic [width_p/8-1:0]       write_mask_i,
  output logic [width_p-1:0]         data_o
);

  localparam int unsigned bytes = width_p / 8;

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < bytes; i++) begin
        if (write_mask_i[i]) mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end
    end
    if (v_i & ~w_i) data_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/bp_mem_lite_ram.sv
// Block-RAM DRAM stand-in: accepts one BedRock lite command at a time and
// answers with a lite response after a fixed programmable delay.
module bp_mem_lite_ram
  import bp_mem_lite_ram_pkg::*;
#(
  parameter int unsigned mem_els_p = 1024,
  parameter int unsigned latency_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [cce_mem_msg_width-1:0] mem_cmd_i,
  input  logic                         mem_cmd_v_i,
  output logic                         mem_cmd_ready_and_o,
  output logic [cce_mem_msg_width-1:0] mem_resp_o,
  output logic                         mem_resp_v_o,
  input  logic                         mem_resp_ready_and_i
);

  localparam int unsigned lg_els = $clog2(mem_els_p);
  localparam int unsigned cnt_w  = (latency_p == 0) ? 1 : $clog2(latency_p + 1);
  localparam logic [cnt_w-1:0] cnt_init = cnt_w'((latency_p == 0) ? 0 : latency_p - 1);

  typedef enum logic [2:0] {e_reset, e_ready, e_read, e_wait, e_resp} state_e;

  state_e                     state_r, state_n;
  logic [cnt_w-1:0]           cnt_r, cnt_n;
  bp_bedrock_mem_msg_s        cmd;
  bp_bedrock_mem_header_s     hdr_r;
  logic [cce_block_width-1:0] data_r, data_n;
  logic                       hdr_load, data_load;
  logic                       cmd_is_wr, hdr_is_rd;

  logic [lg_els-1:0]          ram_addr;
  logic [cce_block_width-1:0] ram_wdata, ram_rdata;
  logic [block_bytes-1:0]     ram_mask;

  logic [lg_block_bytes-1:0]  wr_sm, wr_off, rd_sm, rd_off;
  logic [cce_block_width-1:0] rot;

  assign cmd       = mem_cmd_i;
  assign cmd_is_wr = cmd.header.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
  assign hdr_is_rd = hdr_r.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
  assign ram_addr  = cmd.header.addr[lg_block_bytes +: lg_els];

  // Byte mask and write data: low 2^size cmd bytes replicated so they land at the aligned offset.
  always_comb begin
    logic [lg_block_bytes-1:0] bi;
    logic [lg_block_bytes+2:0] src;
    wr_sm     = size_mask(cmd.header.size);
    wr_off    = cmd.header.addr[lg_block_bytes-1:0] & ~wr_sm;
    ram_mask  = '0;
    ram_wdata = '0;
    bi        = '0;
    src       = '0;
    for (int i = 0; i < block_bytes; i++) begin
      bi          = lg_block_bytes'(i);
      src         = {bi & wr_sm, 3'b000};
      ram_mask[i] = ((bi & ~wr_sm) == wr_off);
      ram_wdata[i*8 +: 8] = cmd.data[src +: 8];
    end
  end

  // Read capture: rotate the row down by the aligned offset, then replicate the low 2^size bytes.
  always_comb begin
    logic [lg_block_bytes+2:0] src;
    rd_sm  = size_mask(hdr_r.size);
    rd_off = hdr_r.addr[lg_block_bytes-1:0] & ~rd_sm;
    rot    = cce_block_width'({ram_rdata, ram_rdata} >> {rd_off, 3'b000});
    data_n = '0;
    src    = '0;
    if (hdr_is_rd) begin
      for (int i = 0; i < block_bytes; i++) begin
        src = {lg_block_bytes'(i) & rd_sm, 3'b000};
        data_n[i*8 +: 8] = rot[src +: 8];
      end
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .width_p (cce_block_width),
    .els_p   (mem_els_p)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (hdr_load),
    .w_i          (hdr_load & cmd_is_wr),
    .addr_i       (ram_addr),
    .data_i       (ram_wdata),
    .write_mask_i (ram_mask),
    .data_o       (ram_rdata)
  );

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    hdr_load  = 1'b0;
    data_load = 1'b0;
    unique case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        if (mem_cmd_v_i) begin
          hdr_load = 1'b1;
          state_n  = e_read;
        end
      end
      e_read: begin
        data_load = 1'b1;
        if (latency_p == 0) begin
          state_n = e_resp;
        end else begin
          cnt_n   = cnt_init;
          state_n = e_wait;
        end
      end
      e_wait: begin
        if (cnt_r == '0) state_n = e_resp;
        else             cnt_n   = cnt_r - cnt_w'(1);
      end
      e_resp: begin
        if (mem_resp_ready_and_i) state_n = e_ready;
      end
      default: state_n = e_reset;
    endcase
  end

  // Handshake flags are registered from the next state so they track state_r exactly.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r             <= e_reset;
      cnt_r               <= '0;
      hdr_r               <= '0;
      data_r              <= '0;
      mem_cmd_ready_and_o <= 1'b0;
      mem_resp_v_o        <= 1'b0;
    end else begin
      state_r             <= state_n;
      cnt_r               <= cnt_n;
      if (hdr_load)  hdr_r  <= cmd.header;
      if (data_load) data_r <= data_n;
      mem_cmd_ready_and_o <= (state_n == e_ready);
      mem_resp_v_o        <= (state_n == e_resp);
    end
  end

  assign mem_resp_o = {data_r, hdr_r};

endmodule

// File: tb/tb_bp_mem_lite_ram.sv
// Self-checking bench for bp_mem_lite_ram: directed vector table, reset
// corner cases and randomized traffic against a byte-array memory model.
module tb_bp_mem_lite_ram;
  import bp_mem_lite_ram_pkg::*;

  localparam int unsigned mem_els = 1024;
  localparam int unsigned latency = 4;
  localparam int unsigned W       = cce_block_width;
  localparam int unsigned MW      = cce_mem_msg_width;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_and_o;
  logic [MW-1:0] mem_resp_o;
  logic          mem_resp_v_o;
  logic          mem_resp_ready_and_i;

  always #5 clk = ~clk;

  bp_mem_lite_ram #(.mem_els_p(mem_els), .latency_p(latency)) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .mem_cmd_i            (mem_cmd_i),
    .mem_cmd_v_i          (mem_cmd_v_i),
    .mem_cmd_ready_and_o  (mem_cmd_ready_and_o),
    .mem_resp_o           (mem_resp_o),
    .mem_resp_v_o         (mem_resp_v_o),
    .mem_resp_ready_and_i (mem_resp_ready_and_i)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [mem_els][block_bytes];

  typedef struct {
    bp_bedrock_mem_type_e mtype;
    logic [39:0]          addr;
    logic [2:0]           size;
    logic [W-1:0]         data;
    int                   stall;
    logic [W-1:0]         exp;
  } vec_t;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                    input logic [39:0] a, input logic [2:0] s);
    bp_bedrock_mem_header_s h;
    h.payload  = 16'($urandom);
    h.size     = bp_bedrock_msg_size_e'(s);
    h.addr     = a;
    h.subop    = 4'($urandom);
    h.msg_type = t;
    return h;
  endfunction

  function automatic logic [W-1:0] rand_block();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory as rows of bytes; accesses are naturally aligned chunks of 2^size bytes.
  task automatic model_exec(input bp_bedrock_mem_header_s h, input logic [W-1:0] d,
                            output logic [W-1:0] r);
    int n, off, row;
    n   = 1 << ((int'(h.size) > lg_block_bytes) ? lg_block_bytes : int'(h.size));
    off = (int'(h.addr % block_bytes) / n) * n;
    row = int'((h.addr / block_bytes) % mem_els);
    r   = '0;
    case (h.msg_type)
      e_bedrock_mem_wr, e_bedrock_mem_uc_wr:
        for (int j = 0; j < n; j++) mdl[row][off + j] = d[j*8 +: 8];
      e_bedrock_mem_rd, e_bedrock_mem_uc_rd:
        for (int i = 0; i < block_bytes; i++) r[i*8 +: 8] = mdl[row][off + (i % n)];
      default: ;
    endcase
  endtask

  // Called on a falling edge with the DUT idle; returns on a falling edge after the response handshake.
  task automatic run_cmd(input bp_bedrock_mem_header_s h, input logic [W-1:0] d, input int stall,
                         output logic [MW-1:0] resp, output int lat, output bit ok, output bit quiet);
    int t;
    ok = 1'b1; quiet = 1'b1; lat = 0; t = 0; resp = '0;
    mem_cmd_i   = {d, h};
    mem_cmd_v_i = 1'b1;
    while (!mem_cmd_ready_and_o) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        timeout("cmd_ready");
        mem_cmd_v_i = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    mem_cmd_i   = '0;
    lat = 1;
    while (!mem_resp_v_o) begin
      if (mem_cmd_ready_and_o) quiet = 1'b0;
      @(negedge clk);
      lat++;
      if (lat > 100) begin
        timeout("resp_v");
        ok = 1'b0;
        return;
      end
    end
    resp = mem_resp_o;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (!mem_resp_v_o || mem_resp_o !== resp || mem_cmd_ready_and_o) quiet = 1'b0;
    end
    mem_resp_ready_and_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_resp_ready_and_i = 1'b0;
  endtask

  task automatic exec(input string tag, input bp_bedrock_mem_header_s h, input logic [W-1:0] d,
                      input int stall, input bit use_model, input logic [W-1:0] exp_tbl);
    logic [MW-1:0] resp;
    logic [W-1:0]  exp_mdl;
    int            lat;
    bit            ok, quiet;
    model_exec(h, d, exp_mdl);
    run_cmd(h, d, stall, resp, lat, ok, quiet);
    if (!ok) return;
    chk({tag, "_lat"},   MW'(lat), MW'(2 + latency));
    chk({tag, "_hdr"},   MW'(resp[mem_header_width-1:0]), MW'(h));
    chk({tag, "_data"},  MW'(resp[MW-1 -: W]), MW'(use_model ? exp_mdl : exp_tbl));
    chk({tag, "_quiet"}, MW'(quiet), MW'(1));
  endtask

  initial begin
    vec_t                   tbl [12];
    logic [W-1:0]           pat, pat2, pat3;
    bp_bedrock_mem_header_s h;
    bit                     quiet;
    logic [39:0]            a;

    for (int i = 0; i < block_bytes; i++) pat[i*8 +: 8] = 8'(i);
    pat2 = pat;
    pat2[64 +: 64] = 64'hDEADBEEF_CAFEF00D;
    pat3 = {8{64'h0123_4567_89AB_CDEF}};

    tbl[0]  = '{e_bedrock_mem_wr,    40'h80_0000_0040, 3'd6, pat,  0, '0};
    tbl[1]  = '{e_bedrock_mem_rd,    40'h80_0000_0040, 3'd6, '0,  10, pat};
    tbl[2]  = '{e_bedrock_mem_wr,    40'h80_0000_0048, 3'd3,
                {{56{8'hA5}}, 64'hDEADBEEF_CAFEF00D}, 0, '0};
    tbl[3]  = '{e_bedrock_mem_rd,    40'h80_0000_004B, 3'd0, '0,   0, {64{8'hCA}}};
    tbl[4]  = '{e_bedrock_mem_rd,    40'h80_0000_0040, 3'd6, '0,   0, pat2};
    tbl[5]  = '{e_bedrock_mem_uc_wr, 40'h80_0000_0000, 3'd6, pat3, 0, '0};
    tbl[6]  = '{e_bedrock_mem_uc_rd, 40'h80_0001_0000, 3'd6, '0,   1, pat3};
    tbl[7]  = '{e_bedrock_mem_rd,    40'h80_0000_0046, 3'd2, '0,   0, {16{32'h0706_0504}}};
    tbl[8]  = '{e_bedrock_mem_amo,   40'h80_0000_0040, 3'd6, {64{8'hFF}}, 0, '0};
    tbl[9]  = '{e_bedrock_mem_rd,    40'h80_0000_0040, 3'd6, '0,   2, pat2};
    tbl[10] = '{e_bedrock_mem_rd,    40'h80_0000_0040, 3'd7, '0,   0, pat2};
    tbl[11] = '{e_bedrock_mem_rd,    40'h80_0000_007F, 3'd1, '0,   0, {32{16'h3F3E}}};

    reset = 1'b1;
    mem_cmd_i = '0;
    mem_cmd_v_i = 1'b0;
    mem_resp_ready_and_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_resp", mem_resp_o, '0);
      chk("rst_ctl", MW'({mem_cmd_ready_and_o, mem_resp_v_o}), '0);
    end
    reset = 1'b0;
    chk("rel_ready0", MW'(mem_cmd_ready_and_o), MW'(0));
    @(negedge clk);
    chk("rel_ready1", MW'(mem_cmd_ready_and_o), MW'(1));

    for (int i = 0; i < 12; i++) begin
      h = mk_hdr(tbl[i].mtype, tbl[i].addr, tbl[i].size);
      exec($sformatf("v%0d", i), h, tbl[i].data, tbl[i].stall, 1'b0, tbl[i].exp);
    end

    // Reset while the read sits in its latency countdown.
    h = mk_hdr(e_bedrock_mem_rd, 40'h80_0000_0040, 3'd6);
    chk("pre_rst_ready", MW'(mem_cmd_ready_and_o), MW'(1));
    mem_cmd_i = {W'(0), h};
    mem_cmd_v_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_resp_v_o || mem_resp_o !== '0 || mem_cmd_ready_and_o) quiet = 1'b0;
    end
    chk("rst_wait_quiet", MW'(quiet), MW'(1));
    reset = 1'b0;
    chk("rel2_ready0", MW'(mem_cmd_ready_and_o), MW'(0));
    @(negedge clk);
    chk("rel2_ready1", MW'(mem_cmd_ready_and_o), MW'(1));
    h = mk_hdr(e_bedrock_mem_rd, 40'h80_0000_0040, 3'd6);
    exec("post_rst_rd", h, '0, 0, 1'b0, pat2);

    // Randomized traffic over eight rows, first filled so every read hits known data.
    for (int r = 0; r < 8; r++) begin
      a = {24'($urandom), 10'(r), 6'd0};
      h = mk_hdr(e_bedrock_mem_wr, a, 3'd6);
      exec($sformatf("init%0d", r), h, rand_block(), 0, 1'b1, '0);
    end
    for (int n = 0; n < 150; n++) begin
      a = {24'($urandom), 10'($urandom_range(0, 7)), 6'($urandom)};
      h = mk_hdr(bp_bedrock_mem_type_e'(4'($urandom_range(0, 5))), a, 3'($urandom_range(0, 7)));
      exec($sformatf("rnd%0d", n), h, rand_block(), $urandom_range(0, 2), 1'b1, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_mem_lite_ram.md
# bp_mem_lite_ram

Block-RAM-backed memory endpoint that sits directly downstream of the tethered testbench top's memory port. It consumes BedRock lite memory commands (header plus full `cce_block_width_p` data) and returns one lite response per command after a programmable delay. It serves as the synthesizable DRAM stand-in for unicore and multicore FPGA/emulation builds.

## Interface
- `bp_params_p`, `BP_CFG_FLOWVAR`: supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `lce_assoc_p` and the `cce` lite msg widths.
- `mem_els_p`, 1024: number of `cce_block_width_p` rows; power of two.
- `latency_p`, 4: extra cycles between array read and response valid; 0 legal.
- `clk_i` — input, 1: sole clock.
- `reset_i` — input, 1: asynchronous, active-high reset.
- `mem_cmd_i` — input, `cce_mem_msg_width_lp`: lite command, `{data, header}`.
- `mem_cmd_v_i` — input, 1: command valid.
- `mem_cmd_ready_and_o` — output, 1: ready-and handshake; transfer when `v & ready`.
- `mem_resp_o` — output, `cce_mem_msg_width_lp`: lite response.
- `mem_resp_v_o` — output, 1: response valid.
- `mem_resp_ready_and_i` — input, 1: consumer ready.

## Operation
- One outstanding command. FSM states are `e_reset`, `e_ready`, `e_read`, `e_wait`, `e_resp`.
- `e_reset` is entered asynchronously on `reset_i`. It moves to `e_ready` on the first clock after deassertion.
- `e_ready`: `ready_and_o=1`. On handshake, register the header, drive the array access, and go to `e_read`.
- `e_read`: capture the array output (sync-read, 1 cycle). If `latency_p==0`, go to `e_resp`; otherwise load the counter with `latency_p-1` and go to `e_wait`.
- `e_wait`: decrement the counter. At 0, go to `e_resp`.
- `e_resp`: `resp_v_o=1` and the output is held stable. On `resp_ready_and_i`, go to `e_ready`. The next command cannot be accepted in the same cycle.
- Row index is `addr[lg(block_bytes) +: lg(mem_els_p)]`. Upper address bits are ignored, so addresses alias and wrap.
- Size: `header.size` encodes 2^size bytes, from 1 B to `block_bytes`. The byte offset is `addr[lg(block_bytes)-1:0]`, aligned down to the size.
- `e_bedrock_mem_wr` / `e_bedrock_mem_uc_wr`:
  - Write the low 2^size bytes of cmd data at the offset, using a byte mask; other bytes are unchanged.
  - Response data is all zero.
- `e_bedrock_mem_rd` / `e_bedrock_mem_uc_rd`:
  - Response data is the row rotated right by the offset bytes.
  - The low 2^size bytes are then replicated to fill the block.
  - A full-block read returns the row unrotated when the offset is 0.
- Any other `msg_type`: no array write, and response data is all zero.
- The response header is the command header echoed unchanged, including `payload`.
- Reset mid-operation: any in-flight command is dropped and no response is issued. Array contents are not reset; they are undefined until written.

## Timing
- Reset values: `mem_cmd_ready_and_o=0`, `mem_resp_v_o=0`, `mem_resp_o=0`.
- Command accepted at cycle t gives `resp_v_o` at t+2+`latency_p`.
- Minimum command-to-command spacing is 3+`latency_p` cycles with an always-ready consumer.
- A write is visible to any command accepted after its response handshake.
- The counter width is `clog2(latency_p+1)`, minimum 1.
- The consumer may hold `ready` low indefinitely. No timeout.

## Structure
- Use the `bp_common_pkg` BedRock mem header typedefs via `declare_bp_bedrock_mem_if(..., cce)`.
- Add a local FSM `typedef enum` only; no new package constants.
- One sub-module: `bsg_mem_1rw_sync_mask_write_byte`, width `cce_block_width_p`, depth `mem_els_p`.
- Rotate/replicate logic and the byte-mask generator stay inline. They are combinational, in the `e_read` capture path.

## Test plan
- Reset held 5 cycles, then released → outputs 0 during reset; `ready_and_o=1` exactly one cycle after release.
- 64 B write of pattern `0x00..3F` to `0x8000_0040`, then 64 B read of the same address, `latency_p=4` → write resp data 0, header echoed; read data equals the pattern; read resp valid at t+6.
- 8 B write `0xDEADBEEF_CAFEF00D` at `0x8000_0048`, then 1 B read at `0x8000_004B`:
  - resp data is byte `0xCA` replicated 64×;
  - adjacent bytes from the prior pattern are intact.
- Consumer holds `resp_ready_and_i=0` for 10 cycles → `resp_v_o` and `mem_resp_o` stay stable, and `cmd_ready_and_o` stays 0 throughout.
- Aliasing with `mem_els_p=1024`: write `0x8000_0000` then read `0x8001_0000` → same row returned.
- Assert `reset_i` during `e_wait` → no response emitted; after release, a fresh read returns data written before the reset.
